bezier_curve_gen: RTL
=====================

# bezier_curve_gen

Parametrised Bézier curve point generator for the display raster path. It produces quadratic or cubic curves at a configurable coordinate width and step resolution. Each point is computed with exact integer Bernstein arithmetic and round-half-up. Points stream out over a valid/ready handshake, with last-point flagging and abort, so the downstream line or pixel writer can apply backpressure.

## Interface
Parameters:
- X_WIDTH, 10, width of horizontal coordinates.
- Y_WIDTH, 9, width of vertical coordinates.
- STEP_BITS, 10, curve resolution; N = 2^STEP_BITS; parameter u steps 0..N, giving N+1 points.

Ports (clock domain and reset: one clock; reset is synchronous and active-low):
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin a curve; accepted only when ready=1.
- abort  in  1  terminate the current curve.
- mode  in  1  0 = quadratic (P0..P2), 1 = cubic (P0..P3).
- x0, x1, x2, x3  in  X_WIDTH each  control point horizontals.
- y0, y1, y2, y3  in  Y_WIDTH each  control point verticals.
- ready  out  1  idle, able to accept start.
- point_valid  out  1  horizontal/vertical hold a valid point.
- point_ready  in  1  downstream accepts the point.
- horizontal  out  X_WIDTH  point x.
- vertical  out  Y_WIDTH  point y.
- last  out  1  qualifies the final point (u = N).

## Operation
- States: IDLE, POWERS, WEIGHTS, SUM, EMIT.
- IDLE:
  - ready=1.
  - start=1 captures mode, all eight coordinates and u=0, then goes to POWERS.
  - Inputs may change after capture without effect.
- POWERS: with v = N−u, register u², u·v and v² (each 2·STEP_BITS+1 bits wide, so u=N fits).
- WEIGHTS:
  - Cubic: w0=v³, w1=3uv², w2=3u²v, w3=u³.
  - Quadratic: w0=v², w1=2uv, w2=u², w3=0.
  - Weights are unsigned and always sum to N³ (cubic) or N² (quadratic).
- SUM:
  - num = Σ wi·Pi, separately for x and y, at full width with no truncation.
  - Result = (num + half) >> shift.
  - Cubic: shift = 3·STEP_BITS, half = N³/2. Quadratic: shift = 2·STEP_BITS, half = N²/2.
  - The result always lies within the control-point hull, so it fits the output width without saturation.
- EMIT:
  - point_valid=1; last=1 when u=N.
  - Outputs are held stable while point_ready=0.
  - On handshake with u<N: u increments and the state returns to POWERS.
  - On handshake with u=N: return to IDLE.
- Endpoints are exact: u=0 yields P0; u=N yields P3 (cubic) or P2 (quadratic).
- Multiplier sharing and DSP mapping are free, provided the cycle timing below holds.

## Timing
- Reset values: ready=1, point_valid=0, last=0, horizontal=0, vertical=0, state IDLE, u=0. Reset wins over every other input.
- Start accepted at cycle T gives states POWERS@T+1, WEIGHTS@T+2, SUM@T+3, and point_valid=1 from T+4.
- Handshake at cycle E with u<N: point_valid=0 at E+1..E+3 and 1 again at E+4. With point_ready held high this gives 1 point per 4 cycles.
- Final handshake at cycle E: ready=1 and point_valid=0 at E+1. A start at E+1 is legal.
- start while ready=0 is ignored, with no capture or restart.
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE with point_valid=0, last=0 and ready=1.
  - A pending point is dropped, even if point_ready=1 in the same cycle.
  - abort has priority over handshake; abort in IDLE is a no-op.
  - start and abort together in IDLE: start is accepted.
- Reset mid-curve: outputs return to reset values on the next edge; no stale point is emitted afterwards.
- Outputs are zeroed (horizontal=vertical=0) whenever point_valid=0.

## Test plan
- Degenerate cubic, all Pi=(100,50), STEP_BITS=10, point_ready=1 -> exactly 1025 points, all (100,50); last only on point 1025; ready=1 the cycle after.
- Cubic P=(0,0),(0,511),(1023,511),(1023,0) -> first point (0,0), last point (1023,0), point 513 (u=512) = (512,383).
- Quadratic mode with same inputs except x1=512, x2=1023, y1=511, y2=0 -> point 513 = (512,256), final point (1023,0) with last=1, 1025 points total, x3/y3 ignored.
- STEP_BITS=2 build, cubic x=(0,0,1023,1023), y=0 -> 5 points:
  - x = 0, 160, 512, 863, 1023.
  - start at T gives valids at T+4, T+8, T+12, T+16, T+20.
- Backpressure: point_ready low for 10 cycles at point 7 -> horizontal, vertical and last unchanged throughout; no point lost or duplicated; total count unchanged.
- Control corners:
  - start pulsed while busy -> ignored.
  - abort at point 300 -> point_valid=0 and ready=1 next cycle.
  - reset_n low for 1 cycle mid-curve -> all outputs at reset values next cycle.
  - New start after each -> correct curve from point 1.

Source files
------------

// File: rtl/bezier_curve_gen_if.sv
// bezier_curve_gen_if: curve request (mode, control points, start/abort) and point stream handshake.
interface bezier_curve_gen_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9
);
    logic start;
    logic abort;
    logic mode;
    logic ready;
    logic point_valid;
    logic point_ready;
    logic last;
    logic [X_WIDTH-1:0] x0, x1, x2, x3, horizontal;
    logic [Y_WIDTH-1:0] y0, y1, y2, y3, vertical;
    modport master (
        output start, abort, mode, x0, x1, x2, x3, y0, y1, y2, y3, point_ready,
        input  ready, point_valid, horizontal, vertical, last
    );
    modport slave (
        input  start, abort, mode, x0, x1, x2, x3, y0, y1, y2, y3, point_ready,
        output ready, point_valid, horizontal, vertical, last
    );
endinterface

// File: rtl/bezier_curve_gen.sv
// bezier_curve_gen: streams quadratic/cubic Bezier points, one per four cycles,
// using exact integer Bernstein sums with round-half-up.
module bezier_curve_gen #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9,
    parameter int STEP_BITS = 10
) (
    input logic clk,
    input logic reset_n,
    bezier_curve_gen_if.slave bus
);
    localparam int PW = 2 * STEP_BITS + 1;
    localparam int WW = 3 * STEP_BITS + 1;
    localparam int XN = WW + X_WIDTH + 1;
    localparam int YN = WW + Y_WIDTH + 1;
    localparam logic [STEP_BITS:0] N = {1'b1, {STEP_BITS{1'b0}}};
    localparam logic [2:0] IDLE = 3'd0, POWERS = 3'd1, WEIGHTS = 3'd2, SUM = 3'd3, EMIT = 3'd4;

    logic [2:0] st;
    logic md, pv, lst;
    logic [STEP_BITS:0] u, v;
    logic [X_WIDTH-1:0] cx [4];
    logic [Y_WIDTH-1:0] cy [4];
    logic [PW-1:0] uu, uv, vv;
    logic [WW-1:0] w [4];
    logic [WW-1:0] wn [4];
    logic [XN-1:0] nx;
    logic [YN-1:0] ny;
    logic [X_WIDTH-1:0] hor;
    logic [Y_WIDTH-1:0] ver;

    assign v = N - u;

    always_comb begin
        wn[0] = md ? WW'(vv) * WW'(v) : WW'(vv);
        wn[1] = md ? WW'(3) * WW'(uv) * WW'(v) : WW'(uv) << 1;
        wn[2] = md ? WW'(3) * WW'(uu) * WW'(v) : WW'(uu);
        wn[3] = md ? WW'(uu) * WW'(u) : '0;
    end

    // Rounding half is folded into the accumulator start value.
    always_comb begin
        nx = md ? XN'(1) << (3 * STEP_BITS - 1) : XN'(1) << (2 * STEP_BITS - 1);
        ny = md ? YN'(1) << (3 * STEP_BITS - 1) : YN'(1) << (2 * STEP_BITS - 1);
        for (int i = 0; i < 4; i++) begin
            nx = nx + XN'(w[i]) * XN'(cx[i]);
            ny = ny + YN'(w[i]) * YN'(cy[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (st == IDLE && bus.start) begin
            md <= bus.mode;
            cx <= '{bus.x0, bus.x1, bus.x2, bus.x3};
            cy <= '{bus.y0, bus.y1, bus.y2, bus.y3};
        end
        if (st == POWERS) begin
            uu <= PW'(u) * PW'(u);
            uv <= PW'(u) * PW'(v);
            vv <= PW'(v) * PW'(v);
        end
        if (st == WEIGHTS)
            w <= wn;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st <= IDLE;
            u <= '0;
            pv <= 1'b0;
            lst <= 1'b0;
            hor <= '0;
            ver <= '0;
        end else if (bus.abort && st != IDLE) begin
            st <= IDLE;
            pv <= 1'b0;
            lst <= 1'b0;
            hor <= '0;
            ver <= '0;
        end else begin
            case (st)
                IDLE: if (bus.start) begin
                    u <= '0;
                    st <= POWERS;
                end
                POWERS: st <= WEIGHTS;
                WEIGHTS: st <= SUM;
                SUM: begin
                    hor <= X_WIDTH'(md ? nx >> (3 * STEP_BITS) : nx >> (2 * STEP_BITS));
                    ver <= Y_WIDTH'(md ? ny >> (3 * STEP_BITS) : ny >> (2 * STEP_BITS));
                    lst <= (u == N);
                    pv <= 1'b1;
                    st <= EMIT;
                end
                EMIT: if (bus.point_ready) begin
                    pv <= 1'b0;
                    lst <= 1'b0;
                    hor <= '0;
                    ver <= '0;
                    u <= lst ? u : u + (STEP_BITS + 1)'(1);
                    st <= lst ? IDLE : POWERS;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.ready = (st == IDLE);
    assign bus.point_valid = pv;
    assign bus.last = lst;
    assign bus.horizontal = hor;
    assign bus.vertical = ver;
endmodule
